// File: rtl/sbentsrc_ctrl_if.sv
// sbentsrc_ctrl_if: valid/ready word delivery channel between the entropy
// source controller (master) and the downstream conditioner or bus consumer.
interface sbentsrc_ctrl_if #(
  parameter int OUT_WIDTH = 32
);
  logic [OUT_WIDTH-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sbentsrc_ctrl.sv
// sbentsrc_ctrl: sequencing controller for the S-box entropy source.
// Enables the source, discards a warm-up period, packs RNG_WIDTH-bit samples
// MSB-first into OUT_WIDTH-bit words and delivers them over out_if.
// Optional feature macro: SBENTSRC_CTRL_HEALTH_EN (repetition-count health
// test with latched alarm and ALARM state). Undefined: o_alarm tied to 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | source off, waiting for i_start; pending word still deliverable
// WARMUP  | source on, discarding WARMUP_CYCLES samples
// COLLECT | source on, packing accepted samples into words
// ALARM   | health test failed; source off, words dropped, wait i_alarm_clr
module sbentsrc_ctrl #(
  parameter int RNG_WIDTH     = 4,
  parameter int OUT_WIDTH     = 32,
  parameter int WARMUP_CYCLES = 64,
  parameter int REP_LIMIT     = 8
) (
  input  logic                 i_clk,
  input  logic                 ff_reset,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [RNG_WIDTH-1:0] i_src_rnd,
  output logic                 o_src_en,
  output logic                 o_alarm,
  input  logic                 i_alarm_clr,
  sbentsrc_ctrl_if.master      out_if
);
  localparam int N     = OUT_WIDTH / RNG_WIDTH;
  localparam int CNT_W = $clog2(N + 1);
  localparam int WRM_W = $clog2(WARMUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [WRM_W-1:0] WRM_LAST = WRM_W'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WARMUP, COLLECT, ALARM} state_t;

  state_t                       state_q, state_d;
  logic [WRM_W-1:0]             warm_q, warm_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]         shift_q, shift_d;
  logic [OUT_WIDTH-1:0]         data_q, data_d;
  logic                         valid_q, valid_d;
  logic                         src_en_q, src_en_d;
  logic [OUT_WIDTH+RNG_WIDTH-1:0] shift_cat;
  logic                         word_done, stall, accept, rep_hit;

  // The shift register is a full word wide so its low nibble always holds
  // the previously accepted sample, which the health test compares against.
  assign shift_cat = {shift_q, i_src_rnd};
  assign word_done = (cnt_q == CNT_LAST);
  assign stall     = word_done && valid_q && !out_if.ready;
  assign accept    = (state_q == COLLECT) && !i_stop && !stall;

`ifdef SBENTSRC_CTRL_HEALTH_EN
  localparam int RUN_W = $clog2(REP_LIMIT + 1);

  logic [RUN_W-1:0] run_q, run_d;

  // Repetition count over accepted samples; zero marks "no sample yet".
  always_comb begin
    run_d   = run_q;
    rep_hit = 1'b0;
    if (state_q == WARMUP) begin
      run_d = '0;
    end else if (accept) begin
      if ((run_q != '0) && (i_src_rnd == shift_q[RNG_WIDTH-1:0])) begin
        run_d = run_q + 1'b1;
      end else begin
        run_d = RUN_W'(1);
      end
      rep_hit = (run_d == RUN_W'(REP_LIMIT));
    end
  end

  // Run counter register.
  always_ff @(posedge i_clk or posedge ff_reset) begin
    if (ff_reset) run_q <= '0;
    else          run_q <= run_d;
  end

  assign o_alarm = (state_q == ALARM);
`else
  logic unused_alarm_clr;

  assign unused_alarm_clr = i_alarm_clr;
  assign rep_hit          = 1'b0;
  assign o_alarm          = 1'b0;
`endif

  // Next-state, counters, packing and output-word handling.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && out_if.ready) valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && !i_stop) begin
          state_d = WARMUP;
          warm_d  = '0;
        end
      end
      WARMUP: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (warm_q == WRM_LAST) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end else begin
          warm_d = warm_q + 1'b1;
        end
      end
      COLLECT: begin
        if (i_stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          shift_d = '0;
        end else if (accept) begin
          if (rep_hit) begin
            state_d = ALARM;
            valid_d = 1'b0;
            cnt_d   = '0;
            shift_d = '0;
          end else begin
            shift_d = shift_cat[OUT_WIDTH-1:0];
            if (word_done) begin
              data_d  = shift_cat[OUT_WIDTH-1:0];
              valid_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      ALARM: begin
        valid_d = 1'b0;
`ifdef SBENTSRC_CTRL_HEALTH_EN
        if (i_alarm_clr) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    src_en_d = (state_d == WARMUP) || (state_d == COLLECT);
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge ff_reset) begin
    if (ff_reset) begin
      state_q  <= IDLE;
      warm_q   <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      src_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      src_en_q <= src_en_d;
    end
  end

  assign o_src_en     = src_en_q;
  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;
endmodule

// File: tb/tb_sbentsrc_ctrl.sv
// tb_sbentsrc_ctrl: scoreboard bench for sbentsrc_ctrl with RNG_WIDTH=4,
// OUT_WIDTH=16, WARMUP_CYCLES=4, REP_LIMIT=4. Expected words are queued as
// samples are driven and compared when the consumer takes them.
module tb_sbentsrc_ctrl;
  localparam int RW = 4;
  localparam int OW = 16;
  localparam int WU = 4;
  localparam int RL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          alarm_clr;
  logic          src_en;
  logic          alarm;
  logic [RW-1:0] rnd;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [OW-1:0] sb_q[$];

  sbentsrc_ctrl_if #(.OUT_WIDTH(OW)) bus ();

  sbentsrc_ctrl #(
    .RNG_WIDTH(RW), .OUT_WIDTH(OW), .WARMUP_CYCLES(WU), .REP_LIMIT(RL)
  ) dut (
    .i_clk(clk), .ff_reset(rst), .i_start(start), .i_stop(stop),
    .i_src_rnd(rnd), .o_src_en(src_en), .o_alarm(alarm),
    .i_alarm_clr(alarm_clr), .out_if(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [RW-1:0] s);
    rnd = s;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Consumer side: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.valid && bus.ready) begin
      if (sb_q.size() == 0) check("sb_underflow", 32'(sb_q.size()), 32'd1);
      else                  check("sb_word", 32'(bus.data), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; alarm_clr = 1'b0; rnd = '0;
    bus.ready = 1'b1;
    #3;
    check("rst_en",    32'(src_en),   32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_alarm", 32'(alarm),    32'd0);
    check("rst_data",  32'(bus.data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Basic capture; warm-up samples are distinct so a short warm-up leaks in.
    pulse_start();
    check("start_en", 32'(src_en), 32'd1);
    feed(4'hE); feed(4'hD); feed(4'hC); feed(4'hB);
    check("warmup_valid", 32'(bus.valid), 32'd0);
    sb_q.push_back(16'h1234);
    feed(4'h1); feed(4'h2); feed(4'h3);
    check("early_valid", 32'(bus.valid), 32'd0);
    feed(4'h4);
    check("basic_valid", 32'(bus.valid), 32'd1);
    check("basic_data",  32'(bus.data),  32'h1234);
    sb_q.push_back(16'h5678);
    feed(4'h5);
    check("valid_one_cycle", 32'(bus.valid), 32'd0);
    feed(4'h6); feed(4'h7); feed(4'h8);
    check("word2_data", 32'(bus.data), 32'h5678);

    // Backpressure: final sample of the next word stalls until ready.
    bus.ready = 1'b0;
    sb_q.push_back(16'h9ABC);
    feed(4'h9); feed(4'hA); feed(4'hB);
    feed(4'hC);
    check("stall_valid", 32'(bus.valid), 32'd1);
    check("stall_data",  32'(bus.data),  32'h5678);
    feed(4'hC);
    check("stall_hold", 32'(bus.data), 32'h5678);
    bus.ready = 1'b1;
    feed(4'hC);
    check("load_on_hs_valid", 32'(bus.valid), 32'd1);
    check("load_on_hs_data",  32'(bus.data),  32'h9ABC);

    // Stop mid-word, then restart with a clean word; i_start mid-word ignored.
    feed(4'h1); feed(4'h2);
    pulse_stop();
    check("stop_en",    32'(src_en),    32'd0);
    check("stop_valid", 32'(bus.valid), 32'd0);
    pulse_start();
    feed(4'h0); feed(4'h1); feed(4'h2); feed(4'h3);
    sb_q.push_back(16'h9ABC);
    feed(4'h9);
    start = 1'b1;
    feed(4'hA);
    start = 1'b0;
    feed(4'hB); feed(4'hC);
    check("restart_data", 32'(bus.data), 32'h9ABC);
    pulse_stop();
    check("restart_stop_en", 32'(src_en), 32'd0);

    // Start/stop collision in IDLE.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("collide_en", 32'(src_en), 32'd0);
    tick();
    check("collide_en2",   32'(src_en),    32'd0);
    check("collide_valid", 32'(bus.valid), 32'd0);

    // Health test: warm-up repeats do not count; a differing sample resets the run.
    pulse_start();
    repeat (WU) feed(4'hA);
    sb_q.push_back(16'hAAA5);
    feed(4'hA); feed(4'hA); feed(4'hA); feed(4'h5);
    check("run_reset_alarm", 32'(alarm), 32'd0);
    check("run_reset_data",  32'(bus.data), 32'hAAA5);
    feed(4'hA); feed(4'hA); feed(4'hA);
    check("pre_alarm", 32'(alarm), 32'd0);
`ifdef SBENTSRC_CTRL_HEALTH_EN
    feed(4'hA);
    check("alarm_set",   32'(alarm),     32'd1);
    check("alarm_en",    32'(src_en),    32'd0);
    check("alarm_valid", 32'(bus.valid), 32'd0);
    pulse_start();
    check("alarm_start_ignored", 32'(alarm),  32'd1);
    check("alarm_start_en",      32'(src_en), 32'd0);
    alarm_clr = 1'b1;
    tick();
    alarm_clr = 1'b0;
    check("alarm_clr", 32'(alarm),  32'd0);
    check("clr_en",    32'(src_en), 32'd0);
    pulse_start();
    check("after_clr_start", 32'(src_en), 32'd1);
    pulse_stop();
`else
    sb_q.push_back(16'hAAAA);
    feed(4'hA);
    check("no_alarm",      32'(alarm),    32'd0);
    check("no_alarm_en",   32'(src_en),   32'd1);
    check("no_alarm_data", 32'(bus.data), 32'hAAAA);
    pulse_stop();
`endif

    // Asynchronous reset with a pending word; nothing resumes afterwards.
    pulse_start();
    feed(4'h0); feed(4'h1); feed(4'h2); feed(4'h3);
    bus.ready = 1'b0;
    feed(4'h1); feed(4'h2); feed(4'h3); feed(4'h4);
    check("pre_rst_valid", 32'(bus.valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_en",    32'(src_en),    32'd0);
    check("arst_valid", 32'(bus.valid), 32'd0);
    check("arst_alarm", 32'(alarm),     32'd0);
    check("arst_data",  32'(bus.data),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.ready = 1'b1;
    repeat (3) tick();
    check("post_rst_en",    32'(src_en),    32'd0);
    check("post_rst_valid", 32'(bus.valid), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sbentsrc_ctrl.md
# sbentsrc_ctrl

Sequencing controller for the S-box entropy source. Enables the source, discards a programmable warm-up period, packs successive RNG_WIDTH-bit raw samples into OUT_WIDTH-bit words and delivers them over a valid/ready interface. An optional repetition-count health test raises a latched alarm and shuts the source down. The block sits between the free-running entropy source and the downstream conditioner or bus consumer.

## Interface
Parameters:
- RNG_WIDTH, 4: raw sample width; matches the entropy source output width.
- OUT_WIDTH, 32: delivered word width; must be an integer multiple of RNG_WIDTH. N = OUT_WIDTH/RNG_WIDTH.
- WARMUP_CYCLES, 64: number of samples discarded after enable; must be ≥ 1.
- REP_LIMIT, 8: number of consecutive identical samples that triggers the alarm; must be ≥ 2.

Ports:
- i_clk  in  1  clock; all samples are taken on its rising edge.
- ff_reset  in  1  reset, asynchronous, active-high.
- i_start  in  1  start request; acted on in IDLE only.
- i_stop  in  1  abort request; acted on in WARMUP/COLLECT.
- i_src_rnd  in  RNG_WIDTH  registered raw sample from the entropy source.
- o_src_en  out  1  entropy source enable, registered.
- o_data  out  OUT_WIDTH  packed word; first sample in the MSBs.
- o_valid  out  1  o_data holds an unconsumed word.
- i_ready  in  1  consumer accepts o_data when o_valid && i_ready.
- o_alarm  out  1  latched health-test failure.
- i_alarm_clr  in  1  clears the alarm; acted on in ALARM only.

## Operation
- States: IDLE, WARMUP, COLLECT, ALARM. o_src_en = 1 exactly in WARMUP and COLLECT.
- IDLE: on i_start && !i_stop, go to WARMUP and clear the warm-up counter.
- WARMUP: one sample is discarded per cycle. After WARMUP_CYCLES cycles, go to COLLECT with sample count 0. i_stop returns the block to IDLE.
- COLLECT: a sample is accepted each cycle unless stalled. On acceptance, shift {shift, i_src_rnd} and increment the count. When the count reaches N-1 and the sample is accepted:
  - load o_data = {shift, i_src_rnd};
  - set o_valid;
  - reset the count to 0.
- Stall: only the final (Nth) sample of a word stalls, and only when o_valid && !i_ready. A handshake and a load in the same cycle are legal, giving a 1-word/N-cycle throughput.
- i_stop in COLLECT: go to IDLE and discard the partial word. Any pending o_data/o_valid is retained until consumed.
- i_start in a non-IDLE state is ignored. i_start and i_stop together in IDLE: stop wins, so the block stays in IDLE.
- Health test (accepted samples only):
  - The first sample after entering COLLECT sets the run count to 1.
  - An equal sample increments the run count; a differing sample resets it to 1.
  - When the run count reaches REP_LIMIT, go to ALARM.
- ALARM:
  - o_alarm = 1 and o_src_en = 0.
  - o_valid is forced to 0; both the pending word and the partial word are discarded.
  - i_alarm_clr moves the block to IDLE and clears o_alarm. i_start is ignored in this state.
- o_valid clears on a handshake unless a new word is loaded in the same cycle.

## Timing
- Reset values:
  - state IDLE;
  - o_src_en, o_valid, o_alarm = 0;
  - o_data, the shift register and all counters = 0.
- i_start sampled at edge 0 → o_src_en = 1 after edge 0.
- Edges 1..WARMUP_CYCLES discard samples. Edges WARMUP_CYCLES+1 .. WARMUP_CYCLES+N accept samples.
- o_valid rises after edge WARMUP_CYCLES+N.
- o_src_en falls one edge after i_stop, or after the alarm-triggering sample.
- o_alarm rises on the edge that accepts the REP_LIMIT-th identical sample.
- A ff_reset assertion mid-operation returns everything to the reset values immediately. Nothing is resumed after reset.

## Configuration
- SBENTSRC_CTRL_HEALTH_EN defined: the repetition-count test and the ALARM state are implemented as above.
- Undefined:
  - no run counter is implemented;
  - o_alarm is tied to 0;
  - ALARM is unreachable and i_alarm_clr is ignored;
  - all other behaviour is unchanged.

## Test plan
Parameters: RNG_WIDTH=4, OUT_WIDTH=16, WARMUP_CYCLES=4, REP_LIMIT=4; health test enabled unless noted.
- Reset: assert ff_reset mid-clock → o_src_en=0, o_valid=0, o_alarm=0, o_data=16'h0000 with no clock edge required.
- Basic capture: pulse i_start, drive samples 4'h1,2,3,4 at edges 5..8, i_ready=1 → o_valid=1 after edge 8, o_data=16'h1234, one cycle only.
- Backpressure: i_ready=0 with word 16'h1234 pending, next samples 5,6,7,8 → 8 stalls and is held. Raise i_ready → 16'h1234 is consumed, then o_data=16'h5678 on the next edge with no lost or duplicated sample.
- Health alarm: drive 4'hA for 4 consecutive accepted samples → o_alarm=1 and o_src_en=0 after the 4th edge, o_valid=0. i_start is ignored. i_alarm_clr → IDLE, o_alarm=0. Repeat with the macro undefined → no alarm, o_data=16'hAAAA.
- Stop mid-word: i_stop after samples 1,2 → IDLE, o_src_en=0. Restart with samples 9,A,B,C → o_data=16'h9ABC, with no stale nibbles.
- Start/stop collision in IDLE → block stays in IDLE, o_src_en=0.
